// File: rtl/rb_ctrl_pkg.sv
// Shared types and sizing helpers for the ring-buffer burst sequencer.
package rb_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_EMPTY,
    ST_REQ,
    ST_FILL,
    ST_DRAIN
  } rb_ctrl_state_e;

  function automatic int unsigned rb_depth(input int unsigned num_lane,
                                           input int unsigned burst_length);
    return num_lane * burst_length;
  endfunction

  function automatic int unsigned rb_occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Counter width that stays legal for a count of one.
  function automatic int unsigned rb_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ring_buffer_burst_ctrl_if.sv
// DMA-side and consumer-side handshakes of the ring-buffer burst sequencer.
interface ring_buffer_burst_ctrl_if;

  logic burst_req;
  logic burst_ack;
  logic lane_valid;
  logic rb_wen;
  logic rb_ren;
  logic out_valid;
  logic out_ready;
  logic dout_valid;

  modport master (
    output burst_req, rb_wen, rb_ren, out_valid, dout_valid,
    input  burst_ack, lane_valid, out_ready
  );

  modport slave (
    input  burst_req, rb_wen, rb_ren, out_valid, dout_valid,
    output burst_ack, lane_valid, out_ready
  );

endinterface

// File: rtl/rb_occupancy_counter.sv
// Buffer word count with overflow guard; reads and writes may share a cycle.
module rb_occupancy_counter
  import rb_ctrl_pkg::*;
#(
  parameter int unsigned NUM_LANE = 2,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned OCC_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_req,
  input  logic             rd_ready,
  output logic             wr_en,
  output logic             rd_en,
  output logic             out_valid,
  output logic             overflow,
  output logic [OCC_W-1:0] occupancy
);

  localparam int unsigned SUM_W = OCC_W + 1;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [SUM_W-1:0] occ_after_wr;

  assign out_valid = (occ_q != '0);
  assign rd_en     = out_valid & rd_ready;

  // Level after a beat lands, net of any read in the same cycle.
  assign occ_after_wr = SUM_W'(occ_q) + SUM_W'(NUM_LANE) - SUM_W'(rd_en);
  assign overflow     = wr_req & (occ_after_wr > SUM_W'(DEPTH));
  assign wr_en        = wr_req & ~overflow;

  always_comb begin
    occ_d = occ_q;
    if (wr_en) begin
      occ_d = OCC_W'(occ_after_wr);
    end else if (rd_en) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: rtl/ring_buffer_burst_ctrl.sv
// Burst sequencer for the lane-wide ring buffer: requests DMA bursts, gates writes, drains reads.
// Optional fill-stall cycle counter is enabled with RB_CTRL_STALL_CNT_EN.
module ring_buffer_burst_ctrl
  import rb_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_LANE     = 2,
  parameter  int unsigned BURST_LENGTH = 8,
  parameter  int unsigned RD_LATENCY   = 1,
  parameter  int unsigned CNT_W        = 16,
  localparam int unsigned DEPTH        = rb_depth(NUM_LANE, BURST_LENGTH),
  localparam int unsigned OCC_W        = rb_occ_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_bursts,
  output logic                   busy,
  output logic                   done,
  output logic [OCC_W-1:0]       occupancy,
  output logic                   protocol_err,
`ifdef RB_CTRL_STALL_CNT_EN
  output logic [31:0]            fill_stall_cnt,
`endif
  ring_buffer_burst_ctrl_if.master bus
);

  localparam int unsigned BEAT_W = rb_cnt_w(BURST_LENGTH);

  rb_ctrl_state_e          state_q, state_d;
  logic [CNT_W-1:0]        bursts_left_q, bursts_left_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [RD_LATENCY-1:0]   rd_pipe_q, rd_pipe_d;

  logic                    wr_req;
  logic                    wr_en;
  logic                    rd_en;
  logic                    out_valid;
  logic                    overflow;
  logic [OCC_W-1:0]        occ;

  assign wr_req = (state_q == ST_FILL) & bus.lane_valid;

  rb_occupancy_counter #(
    .NUM_LANE (NUM_LANE),
    .DEPTH    (DEPTH),
    .OCC_W    (OCC_W)
  ) u_occ (
    .clk       (clk),
    .rst       (rst),
    .wr_req    (wr_req),
    .rd_ready  (bus.out_ready),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .out_valid (out_valid),
    .overflow  (overflow),
    .occupancy (occ)
  );

  // Sequencer: one burst in flight, the next only once the buffer has fully emptied.
  always_comb begin
    state_d       = state_q;
    bursts_left_d = bursts_left_q;
    beat_cnt_d    = beat_cnt_q;
    done_d        = 1'b0;
    err_d         = err_q | (bus.lane_valid & (state_q != ST_FILL)) | overflow;
    rd_pipe_d     = RD_LATENCY'({rd_pipe_q, rd_en});

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_bursts == '0) begin
            done_d = 1'b1;
          end else begin
            bursts_left_d = num_bursts;
            state_d       = ST_WAIT_EMPTY;
          end
        end
      end
      ST_WAIT_EMPTY: begin
        if (occ == '0) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.burst_ack) begin
          beat_cnt_d = '0;
          state_d    = ST_FILL;
        end
      end
      ST_FILL: begin
        if (bus.lane_valid) begin
          if (beat_cnt_q == BEAT_W'(BURST_LENGTH - 1)) begin
            beat_cnt_d    = '0;
            bursts_left_d = bursts_left_q - CNT_W'(1);
            state_d       = (bursts_left_q == CNT_W'(1)) ? ST_DRAIN : ST_WAIT_EMPTY;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Wait for the last read's data to leave the buffer's output pipeline too.
        if ((occ == '0) && (rd_pipe_q == '0)) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      bursts_left_q <= '0;
      beat_cnt_q    <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      rd_pipe_q     <= '0;
    end else begin
      state_q       <= state_d;
      bursts_left_q <= bursts_left_d;
      beat_cnt_q    <= beat_cnt_d;
      done_q        <= done_d;
      err_q         <= err_d;
      rd_pipe_q     <= rd_pipe_d;
    end
  end

`ifdef RB_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Cycles the DMA left the buffer starved mid-burst; saturating.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      stall_cnt_d = '0;
    end else if ((state_q == ST_FILL) && !bus.lane_valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fill_stall_cnt = stall_cnt_q;
`endif

  assign busy           = (state_q != ST_IDLE);
  assign done           = done_q;
  assign occupancy      = occ;
  assign protocol_err   = err_q;
  assign bus.burst_req  = (state_q == ST_REQ);
  assign bus.rb_wen     = wr_en;
  assign bus.rb_ren     = rd_en;
  assign bus.out_valid  = out_valid;
  assign bus.dout_valid = rd_pipe_q[RD_LATENCY-1];

endmodule

// File: tb/tb_ring_buffer_burst_ctrl.sv
// Directed bench for ring_buffer_burst_ctrl with a cycle-level reference model of the sequencing rules.
module tb_ring_buffer_burst_ctrl;

  localparam int NL    = 2;
  localparam int BL    = 8;
  localparam int RL    = 1;
  localparam int DEPTH = NL * BL;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_bursts;
  logic        busy;
  logic        done;
  logic [4:0]  occupancy;
  logic        protocol_err;
`ifdef RB_CTRL_STALL_CNT_EN
  logic [31:0] fill_stall_cnt;
`endif

  ring_buffer_burst_ctrl_if bus_if ();

  ring_buffer_burst_ctrl #(
    .NUM_LANE     (NL),
    .BURST_LENGTH (BL),
    .RD_LATENCY   (RL),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_bursts   (num_bursts),
    .busy         (busy),
    .done         (done),
    .occupancy    (occupancy),
    .protocol_err (protocol_err),
`ifdef RB_CTRL_STALL_CNT_EN
    .fill_stall_cnt (fill_stall_cnt),
`endif
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 waiting for empty buffer, 2 requesting, 3 filling, 4 draining
  int     m_phase, m_occ, m_bursts, m_beats;
  bit     m_done, m_err;
  bit     m_hist[$];
  longint m_stall;

  function automatic bit e_ren();
    return (m_occ > 0) && bus_if.out_ready;
  endfunction

  function automatic bit e_wen();
    return (m_phase == 3) && bus_if.lane_valid && (m_occ + NL - int'(e_ren()) <= DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    bit ren, wen;
    int in_flight;
    if (rst) begin
      m_phase = 0; m_occ = 0; m_bursts = 0; m_beats = 0;
      m_done = 0; m_err = 0; m_stall = 0;
      m_hist = {};
      for (int i = 0; i < RL; i++) m_hist.push_back(1'b0);
    end else begin
      ren = e_ren();
      wen = e_wen();
      in_flight = 0;
      foreach (m_hist[i]) in_flight += int'(m_hist[i]);
      if (bus_if.lane_valid && !wen) m_err = 1;
      m_done = 0;
      case (m_phase)
        0: if (start) begin
             m_stall = 0;
             if (num_bursts == 0) m_done = 1;
             else begin m_bursts = int'(num_bursts); m_phase = 1; end
           end
        1: if (m_occ == 0) m_phase = 2;
        2: if (bus_if.burst_ack) begin m_beats = 0; m_phase = 3; end
        3: if (bus_if.lane_valid) begin
             m_beats++;
             if (m_beats == BL) begin
               m_beats = 0;
               m_bursts--;
               m_phase = (m_bursts == 0) ? 4 : 1;
             end
           end else m_stall++;
        4: if (m_occ == 0 && in_flight == 0) begin m_done = 1; m_phase = 0; end
        default: m_phase = 0;
      endcase
      m_occ = m_occ + (wen ? NL : 0) - (ren ? 1 : 0);
      m_hist.push_back(ren);
      void'(m_hist.pop_front());
    end
  end

  // ---------------- per-cycle compare + event counters ----------------
  int cnt_wen, cnt_ren, cnt_dout, cnt_done, cnt_req, cnt_busy, occ_max;
  bit prev_req;

  task automatic clear_cnt();
    cnt_wen = 0; cnt_ren = 0; cnt_dout = 0; cnt_done = 0;
    cnt_req = 0; cnt_busy = 0; occ_max = 0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("busy",       busy,              m_phase != 0);
      check("burst_req",  bus_if.burst_req,  m_phase == 2);
      check("rb_wen",     bus_if.rb_wen,     e_wen());
      check("rb_ren",     bus_if.rb_ren,     e_ren());
      check("out_valid",  bus_if.out_valid,  m_occ > 0);
      check("dout_valid", bus_if.dout_valid, m_hist[0]);
      check("occupancy",  occupancy,         m_occ);
      check("done",       done,              m_done);
      check("protocol_err", protocol_err,    m_err);
`ifdef RB_CTRL_STALL_CNT_EN
      check("fill_stall_cnt", fill_stall_cnt, m_stall);
`endif
      cnt_wen  += int'(bus_if.rb_wen);
      cnt_ren  += int'(bus_if.rb_ren);
      cnt_dout += int'(bus_if.dout_valid);
      cnt_done += int'(done);
      cnt_busy += int'(busy);
      if (bus_if.burst_req && !prev_req) cnt_req++;
      if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
      prev_req = bus_if.burst_req;
    end else begin
      prev_req = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int nb);
    num_bursts = 16'(nb);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!bus_if.burst_req && n < 200) begin tick(); n++; end
    check({nm, "_req_seen"}, bus_if.burst_req, 1);
    check({nm, "_req_occ0"}, occupancy, 0);
  endtask

  task automatic do_burst(input string nm, input int ack_delay);
    wait_req(nm);
    repeat (ack_delay) tick();
    bus_if.burst_ack = 1'b1;
    tick();
    bus_if.burst_ack  = 1'b0;
    bus_if.lane_valid = 1'b1;
    repeat (BL) tick();
    bus_if.lane_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (cnt_done == 0 && n < 500) begin tick(); n++; end
    check({nm, "_done_seen"}, cnt_done, 1);
    repeat (3) tick();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1; start = 1'b0; num_bursts = '0;
    bus_if.burst_ack = 1'b0; bus_if.lane_valid = 1'b0; bus_if.out_ready = 1'b0;
    prev_req = 1'b0;
    clear_cnt();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset
    repeat (5) tick();
    check("t1_busy", busy, 0);
    check("t1_occ", occupancy, 0);
    check("t1_req", bus_if.burst_req, 0);
    check("t1_err", protocol_err, 0);
    check("t1_out_valid", bus_if.out_valid, 0);

    // 2: single burst, buffered fully before draining
    clear_cnt();
    start_job(1);
    do_burst("t2", 2);
    tick();
    check("t2_wen_cnt", cnt_wen, 8);
    check("t2_occ_full", occupancy, 16);
    check("t2_ren_cnt_stalled", cnt_ren, 0);
    check("t2_busy", busy, 1);
    bus_if.out_ready = 1'b1;
    wait_done("t2");
    check("t2_ren_cnt", cnt_ren, 16);
    check("t2_dout_cnt", cnt_dout, 16);
    check("t2_done_cnt", cnt_done, 1);
    check("t2_idle", busy, 0);

    // 3: three bursts with concurrent draining
    clear_cnt();
    start_job(3);
    do_burst("t3a", 0);
    do_burst("t3b", 0);
    do_burst("t3c", 0);
    wait_done("t3");
    check("t3_req_cnt", cnt_req, 3);
    check("t3_wen_cnt", cnt_wen, 24);
    check("t3_ren_cnt", cnt_ren, 48);
    check("t3_occ_bound", occ_max <= 16, 1);
    check("t3_done_cnt", cnt_done, 1);

    // 4: empty job completes immediately
    clear_cnt();
    start_job(0);
    check("t4_done_next", done, 1);
    repeat (3) tick();
    check("t4_done_cnt", cnt_done, 1);
    check("t4_req_cnt", cnt_req, 0);
    check("t4_busy_cnt", cnt_busy, 0);

    // 5: stray beats in IDLE and REQ
    clear_cnt();
    bus_if.lane_valid = 1'b1;
    tick();
    bus_if.lane_valid = 1'b0;
    check("t5_err_idle", protocol_err, 1);
    start_job(1);
    wait_req("t5");
    bus_if.lane_valid = 1'b1;
    tick();
    bus_if.lane_valid = 1'b0;
    check("t5_no_wen", cnt_wen, 0);
    do_burst("t5", 0);
    wait_done("t5");
    check("t5_err_sticky", protocol_err, 1);
    check("t5_ren_cnt", cnt_ren, 16);

    // 6: asynchronous reset mid-fill, then a clean job
    bus_if.out_ready = 1'b0;
    clear_cnt();
    start_job(1);
    wait_req("t6");
    bus_if.burst_ack = 1'b1;
    tick();
    bus_if.burst_ack  = 1'b0;
    bus_if.lane_valid = 1'b1;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_wen", bus_if.rb_wen, 0);
    check("t6_occ", occupancy, 0);
    check("t6_out_valid", bus_if.out_valid, 0);
    check("t6_err_cleared", protocol_err, 0);
    check("t6_req", bus_if.burst_req, 0);
    bus_if.lane_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    clear_cnt();
    bus_if.out_ready = 1'b1;
    start_job(1);
    do_burst("t6", 1);
    wait_done("t6");
    check("t6_ren_cnt", cnt_ren, 16);
    check("t6_dout_cnt", cnt_dout, 16);
    check("t6_done_cnt", cnt_done, 1);
    check("t6_err_clean", protocol_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
